tlul_host_arb: RTL

//  N-to-1 TL-UL host arbiter sharing one device port (typically a tlul_rob-fronted crossbar port) among NUM_HOSTS requesters.

---
 rtl/tlul_host_arb.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/tlul_host_arb.sv
// Round-robin N-to-1 TL-UL host arbiter: host index tagged into the upper a_source bits,
// D responses routed back by that tag, per-host outstanding caps.
module tlul_host_arb #(
    parameter int NUM_HOSTS       = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TL_AIW          = 8,
    localparam int H2D_W          = TL_AIW + 86,
    localparam int D2H_W          = TL_AIW + 52
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_HOSTS*H2D_W-1:0] host_i,
    output logic [NUM_HOSTS*D2H_W-1:0] host_o,
    output logic [H2D_W-1:0]           device_o,
    input  logic [D2H_W-1:0]           device_i,
    output logic                       busy_o,
    output logic                       src_err_o,
    output logic                       rsp_err_o
);
    localparam int IDXW = $clog2(NUM_HOSTS);
    localparam int SRCW = TL_AIW - IDXW;
    localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [1:0]        a_size;
        logic [TL_AIW-1:0] a_source;
        logic [31:0]       a_address;
        logic [3:0]        a_mask;
        logic [31:0]       a_data;
        logic [7:0]        a_user;
        logic              d_ready;
    } h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [1:0]        d_size;
        logic [TL_AIW-1:0] d_source;
        logic              d_sink;
        logic [31:0]       d_data;
        logic [7:0]        d_user;
        logic              d_error;
        logic              a_ready;
    } d2h_t;

    h2d_t req [NUM_HOSTS];
    d2h_t rsp [NUM_HOSTS];
    h2d_t dev_req;
    d2h_t dev_rsp;

    for (genvar g = 0; g < NUM_HOSTS; g++) begin : g_host
        assign req[g]                    = host_i[g*H2D_W +: H2D_W];
        assign host_o[g*D2H_W +: D2H_W]  = rsp[g];
    end
    assign device_o = dev_req;
    assign dev_rsp  = device_i;

    logic                 lock_q, lock_d;
    logic [IDXW-1:0]      grant_q, grant_d, rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]      cnt_q [NUM_HOSTS];
    logic [CNTW-1:0]      cnt_d [NUM_HOSTS];
    logic [NUM_HOSTS-1:0] eligible;
    logic                 win_found, sel_valid, accept;
    logic [IDXW-1:0]      win_idx, sel_idx, tag;
    logic                 tag_ok, dev_d_ready, d_hs;

    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] i);
        return (int'(i) == NUM_HOSTS - 1) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        for (int h = 0; h < NUM_HOSTS; h++) begin
            eligible[h] = req[h].a_valid && (cnt_q[h] < CNT_MAX);
        end
    end

    // First eligible host at or after rr_ptr, wrapping.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_HOSTS; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUM_HOSTS;
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = IDXW'(cand);
            end
        end
    end

    // A held grant ignores eligibility; a host dropping a_valid just stalls the port.
    assign sel_idx     = lock_q ? grant_q : win_idx;
    assign sel_valid   = lock_q ? req[grant_q].a_valid : win_found;
    assign accept      = sel_valid && dev_rsp.a_ready;
    assign tag         = dev_rsp.d_source[TL_AIW-1:SRCW];
    assign tag_ok      = int'(tag) < NUM_HOSTS;
    assign dev_d_ready = tag_ok ? req[tag].d_ready : 1'b1;
    assign d_hs        = dev_rsp.d_valid && dev_d_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q   <= 1'b0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            for (int h = 0; h < NUM_HOSTS; h++) cnt_q[h] <= '0;
        end else begin
            lock_q   <= lock_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            for (int h = 0; h < NUM_HOSTS; h++) cnt_q[h] <= cnt_d[h];
        end
    end

    always_comb begin
        logic inc, dec;
        inc      = 1'b0;
        dec      = 1'b0;
        lock_d   = lock_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (!lock_q) begin
            if (win_found) begin
                if (dev_rsp.a_ready) begin
                    rr_ptr_d = next_idx(win_idx);
                end else begin
                    lock_d  = 1'b1;
                    grant_d = win_idx;
                end
            end
        end else if (accept) begin
            lock_d   = 1'b0;
            rr_ptr_d = next_idx(grant_q);
        end
        // Counters saturate at both ends; simultaneous accept and response cancel.
        for (int h = 0; h < NUM_HOSTS; h++) begin
            inc      = accept && (sel_idx == IDXW'(h));
            dec      = d_hs && tag_ok && (tag == IDXW'(h));
            cnt_d[h] = cnt_q[h];
            if (inc && !dec && cnt_q[h] != CNT_MAX) begin
                cnt_d[h] = cnt_q[h] + 1'b1;
            end else if (dec && !inc && cnt_q[h] != '0) begin
                cnt_d[h] = cnt_q[h] - 1'b1;
            end
        end
    end

    always_comb begin
        dev_req = '0;
        if (sel_valid) begin
            dev_req          = req[sel_idx];
            dev_req.a_source = {sel_idx, req[sel_idx].a_source[SRCW-1:0]};
            dev_req.a_user   = '0;
        end
        dev_req.a_valid = sel_valid;
        dev_req.d_ready = dev_d_ready;

        for (int h = 0; h < NUM_HOSTS; h++) begin
            rsp[h] = '0;
            if (tag_ok && tag == IDXW'(h)) begin
                rsp[h]          = dev_rsp;
                rsp[h].d_source = {{IDXW{1'b0}}, dev_rsp.d_source[SRCW-1:0]};
            end
            rsp[h].a_ready = accept && (sel_idx == IDXW'(h));
        end

        src_err_o = accept && (req[sel_idx].a_source[TL_AIW-1:SRCW] != '0);
        rsp_err_o = 1'b0;
        if (d_hs) begin
            if (!tag_ok) begin
                rsp_err_o = 1'b1;
            end else if (cnt_q[tag] == '0) begin
                rsp_err_o = 1'b1;
            end
        end

        busy_o = lock_q;
        for (int h = 0; h < NUM_HOSTS; h++) begin
            if (cnt_q[h] != '0) busy_o = 1'b1;
        end
    end

endmodule
